// File: rtl/crc_pkg.sv
// Shared definitions for the CRC byte path: bus write-size encodings and
// the mapping from bus size to number of bytes.
package crc_pkg;

    localparam logic [1:0] WR_NONE = 2'b11;
    localparam logic [1:0] WR_BYTE = 2'b00;
    localparam logic [1:0] WR_HALF = 2'b01;
    localparam logic [1:0] WR_WORD = 2'b10;

    typedef logic [2:0] len_t;

    function automatic len_t size_to_len(input logic [1:0] size);
        len_t len;
        case (size)
            WR_BYTE: len = 3'd1;
            WR_HALF: len = 3'd2;
            WR_WORD: len = 3'd4;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/crc_word_unpacker.sv
// Buffers 8/16/32-bit bus writes in a small slot ring and replays them as a
// byte stream with a valid/ready handshake, one byte per cycle.
module crc_word_unpacker
    import crc_pkg::*;
#(
    parameter int DEPTH_WORDS = 2,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  wr_n,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic        flush,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        busy,
    output logic [15:0] bytes_sent,
    output logic        overflow,
    input  logic        ovf_clr
);

    localparam int PW = $clog2(DEPTH_WORDS);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH_WORDS);

    logic [31:0]   slot_data_r [DEPTH_WORDS];
    len_t          slot_len_r  [DEPTH_WORDS];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [1:0]    idx_r;
    logic          valid_r;
    logic          ready_r;
    logic          busy_r;
    logic [15:0]   sent_r;
    logic          ovf_r;

    logic          accept_s;
    logic          xfer_s;
    logic          last_s;
    logic          pop_s;
    logic          ovf_set_s;
    len_t          head_len_s;
    logic [1:0]    sel_s;
    logic [CW-1:0] count_nxt_s;
    logic [7:0]    byte_data_s;

    assign accept_s   = (wr_n != WR_NONE) && ready_r && !flush;
    assign ovf_set_s  = (wr_n != WR_NONE) && !ready_r && !flush;
    assign xfer_s     = valid_r && byte_ready;
    assign head_len_s = slot_len_r[head_r];
    assign last_s     = ({1'b0, idx_r} == (head_len_s - 3'd1));
    assign pop_s      = xfer_s && last_s;

    // Byte lane select within the head slot; the 2-bit subtraction wraps so
    // a 4-byte slot maps idx 0..3 onto lanes 3..0.
    always_comb begin
        if (MSB_FIRST) begin
            sel_s = head_len_s[1:0] - 2'd1 - idx_r;
        end else begin
            sel_s = idx_r;
        end
    end

    // Output byte mux, forced to zero whenever nothing valid is presented.
    always_comb begin
        byte_data_s = 8'h00;
        if (valid_r) begin
            byte_data_s = slot_data_r[head_r][{sel_s, 3'b000} +: 8];
        end else begin
            byte_data_s = 8'h00;
        end
    end

    // Next occupancy; flush overrides any same-cycle push or pop.
    always_comb begin
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = '0;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Slot storage: written at the tail on every accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                slot_data_r[i] <= 32'h0000_0000;
                slot_len_r[i]  <= 3'd0;
            end
        end else if (accept_s) begin
            slot_data_r[tail_r] <= wr_data;
            slot_len_r[tail_r]  <= size_to_len(wr_n);
        end
    end

    // Pointers, byte index, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            idx_r   <= 2'd0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            sent_r  <= 16'h0000;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
            busy_r  <= (count_nxt_s != '0);
            ready_r <= (count_nxt_s != CNT_FULL);
            if (flush) begin
                head_r <= '0;
                tail_r <= '0;
                idx_r  <= 2'd0;
                sent_r <= 16'h0000;
            end else begin
                if (accept_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
                if (xfer_s) begin
                    sent_r <= sent_r + 16'd1;
                    if (last_s) begin
                        idx_r  <= 2'd0;
                        head_r <= head_r + PTR_ONE;
                    end else begin
                        idx_r <= idx_r + 2'd1;
                    end
                end
            end
            // A new overflow event takes priority over a clear request.
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign byte_valid = valid_r;
    assign byte_data  = byte_data_s;
    assign wr_ready   = ready_r;
    assign busy       = busy_r;
    assign bytes_sent = sent_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_crc_word_unpacker.sv
// Directed bench for crc_word_unpacker: LSB-first and MSB-first instances
// share stimulus; emitted bytes are matched against per-instance queues.
module tb_crc_word_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wr_n = 2'b11;
    logic [31:0] wr_data = 32'h0;
    logic        flush = 1'b0;
    logic        byte_ready = 1'b0;
    logic        ovf_clr = 1'b0;

    logic        wr_ready0, bv0, busy0, ovf0;
    logic [7:0]  bd0;
    logic [15:0] sent0;
    logic        wr_ready1, bv1, busy1, ovf1;
    logic [7:0]  bd1;
    logic [15:0] sent1;

    int tests = 0;
    int fails = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    crc_word_unpacker #(.DEPTH_WORDS(2), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .wr_data(wr_data),
        .wr_ready(wr_ready0), .flush(flush), .byte_valid(bv0),
        .byte_data(bd0), .byte_ready(byte_ready), .busy(busy0),
        .bytes_sent(sent0), .overflow(ovf0), .ovf_clr(ovf_clr));

    crc_word_unpacker #(.DEPTH_WORDS(2), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .wr_data(wr_data),
        .wr_ready(wr_ready1), .flush(flush), .byte_valid(bv1),
        .byte_data(bd1), .byte_ready(byte_ready), .busy(busy1),
        .bytes_sent(sent1), .overflow(ovf1), .ovf_clr(ovf_clr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one bus write for a cycle; queue its bytes if it should be accepted.
    task automatic do_write(input logic [1:0] size, input logic [31:0] data, input bit accept);
        int len;
        logic [31:0] d;
        d = data;
        len = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        if (accept) begin
            for (int i = 0; i < len; i++) q0.push_back(d[8*i +: 8]);
            for (int i = len - 1; i >= 0; i--) q1.push_back(d[8*i +: 8]);
        end
        wr_n = size;
        wr_data = data;
        tick();
        wr_n = 2'b11;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        q0.delete();
        q1.delete();
        tick();
        flush = 1'b0;
    endtask

    // Scoreboard: every transfer must match the queue head; stalled bytes must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bv0 && byte_ready) begin
                if (q0.size() == 0) check("extra_byte_lsb", 32'(q0.size()), 32'd1);
                else check("byte_lsb", {24'h0, bd0}, {24'h0, q0.pop_front()});
            end else if (bv0 && q0.size() != 0) begin
                check("hold_lsb", {24'h0, bd0}, {24'h0, q0[0]});
            end
            if (bv1 && byte_ready) begin
                if (q1.size() == 0) check("extra_byte_msb", 32'(q1.size()), 32'd1);
                else check("byte_msb", {24'h0, bd1}, {24'h0, q1.pop_front()});
            end else if (bv1 && q1.size() != 0) begin
                check("hold_msb", {24'h0, bd1}, {24'h0, q1[0]});
            end
        end
    end

    initial begin
        #12;
        check("rst_valid", 32'(bv0), 32'd0);
        check("rst_data", 32'(bd0), 32'd0);
        check("rst_wr_ready", 32'(wr_ready0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_sent", 32'(sent0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        rst_n = 1'b1;
        tick();

        // Word write drains in four consecutive cycles.
        byte_ready = 1'b1;
        do_write(2'b10, 32'hDDCCBBAA, 1'b1);
        check("t1_latency", 32'(bv0), 32'd1);
        repeat (3) tick();
        check("t1_busy_mid", 32'(busy0), 32'd1);
        tick();
        check("t1_busy_end", 32'(busy0), 32'd0);
        check("t1_sent", 32'(sent0), 32'd4);
        check("t1_queue", 32'(q0.size()), 32'd0);

        // Half then byte write back-to-back.
        do_flush();
        check("flush_sent", 32'(sent0), 32'd0);
        do_write(2'b01, 32'h00001234, 1'b1);
        do_write(2'b00, 32'h00000056, 1'b1);
        repeat (2) tick();
        check("t2_busy", 32'(busy0), 32'd0);
        check("t2_sent", 32'(sent0), 32'd3);
        check("t2_queue", 32'(q0.size()), 32'd0);

        // Fill both slots, overflow on third write, then drain.
        do_flush();
        byte_ready = 1'b0;
        do_write(2'b10, 32'h03020100, 1'b1);
        check("t3_ready_one", 32'(wr_ready0), 32'd1);
        do_write(2'b10, 32'h07060504, 1'b1);
        check("t3_full", 32'(wr_ready0), 32'd0);
        check("t3_no_ovf", 32'(ovf0), 32'd0);
        do_write(2'b10, 32'hFFFFFFFF, 1'b0);
        check("t3_ovf", 32'(ovf0), 32'd1);
        byte_ready = 1'b1;
        repeat (8) tick();
        check("t3_busy", 32'(busy0), 32'd0);
        check("t3_sent", 32'(sent0), 32'd8);
        check("t3_queue", 32'(q0.size()), 32'd0);
        check("t3_ovf_sticky", 32'(ovf0), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(ovf0), 32'd0);

        // Stalled handshake: bytes must hold while byte_ready is low.
        do_flush();
        byte_ready = 1'b0;
        do_write(2'b10, 32'hA1B2C3D4, 1'b1);
        for (int i = 0; i < 8; i++) begin
            byte_ready = (i % 2 == 0);
            tick();
        end
        check("t4_busy", 32'(busy0), 32'd0);
        check("t4_sent", 32'(sent0), 32'd4);
        check("t4_queue_msb", 32'(q1.size()), 32'd0);

        // Flush after two bytes, with a colliding byte write.
        do_flush();
        byte_ready = 1'b1;
        do_write(2'b10, 32'h11223344, 1'b1);
        repeat (2) tick();
        check("t5_sent_pre", 32'(sent0), 32'd2);
        byte_ready = 1'b0;
        wr_n = 2'b00;
        wr_data = 32'h00000077;
        do_flush();
        wr_n = 2'b11;
        byte_ready = 1'b1;
        check("t5_valid", 32'(bv0), 32'd0);
        check("t5_sent", 32'(sent0), 32'd0);
        check("t5_ovf", 32'(ovf0), 32'd0);
        repeat (3) tick();
        check("t5_still_idle", 32'(bv0), 32'd0);

        // Asynchronous reset mid-word.
        do_write(2'b10, 32'hCAFEF00D, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check("t6_valid", 32'(bv0), 32'd0);
        check("t6_data", 32'(bd0), 32'd0);
        check("t6_sent", 32'(sent0), 32'd0);
        check("t6_busy", 32'(busy0), 32'd0);
        check("t6_ready", 32'(wr_ready0), 32'd1);
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_after_valid", 32'(bv0), 32'd0);
        check("t6_after_sent", 32'(sent0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
